// File: rtl/id_stage_pkg.sv
// Shared RV32I/RV64I encoding constants and func3 legality helpers for the decode stage.
package id_stage_pkg;

  localparam logic [6:0] INST_TYPE_I = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R = 7'b0110011;
  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;
  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_AUIPC  = 7'b0010111;

  localparam logic [2:0] INST_ADD_SUB = 3'd0;
  localparam logic [2:0] INST_SLLI    = 3'd1;
  localparam logic [2:0] INST_SRI     = 3'd5;

  localparam logic [2:0] INST_LB  = 3'd0;
  localparam logic [2:0] INST_LH  = 3'd1;
  localparam logic [2:0] INST_LW  = 3'd2;
  localparam logic [2:0] INST_LD  = 3'd3;
  localparam logic [2:0] INST_LBU = 3'd4;
  localparam logic [2:0] INST_LHU = 3'd5;
  localparam logic [2:0] INST_LWU = 3'd6;

  localparam logic [2:0] INST_SB = 3'd0;
  localparam logic [2:0] INST_SH = 3'd1;
  localparam logic [2:0] INST_SW = 3'd2;
  localparam logic [2:0] INST_SD = 3'd3;

  localparam logic [2:0] INST_BEQ  = 3'd0;
  localparam logic [2:0] INST_BNE  = 3'd1;
  localparam logic [2:0] INST_BLT  = 3'd4;
  localparam logic [2:0] INST_BGE  = 3'd5;
  localparam logic [2:0] INST_BLTU = 3'd6;
  localparam logic [2:0] INST_BGEU = 3'd7;

  localparam logic [6:0] FUNC7_BASE     = 7'h00;
  localparam logic [6:0] FUNC7_ALT      = 7'h20;
  localparam logic [5:0] SHIFT_HI_LOGIC = 6'h00;
  localparam logic [5:0] SHIFT_HI_ARITH = 6'h10;

  function automatic logic load_ok(input logic [2:0] func3, input logic rv64);
    case (func3)
      INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: return 1'b1;
      INST_LD, INST_LWU:                             return rv64;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic store_ok(input logic [2:0] func3, input logic rv64);
    case (func3)
      INST_SB, INST_SH, INST_SW: return 1'b1;
      INST_SD:                   return rv64;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic branch_ok(input logic [2:0] func3);
    case (func3)
      INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational base-ISA decoder: operand selection, control flags and legality for one instruction.
module id_decode
  import id_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op3,
  output logic [4:0]      rd_addr,
  output logic            reg_wen,
  output logic            mem_ren,
  output logic            mem_wen,
  output logic            illegal,
  output logic            use_rs1,
  output logic            use_rs2
);

  localparam logic RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic            legal;
  logic            writes_rd;

  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign shamt = XLEN'(inst[20 +: SHAMT_W]);

  always_comb begin
    op1       = '0;
    op2       = '0;
    op3       = '0;
    legal     = 1'b0;
    writes_rd = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      INST_TYPE_I: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        op1       = rs1_data;
        // Shift-immediates reuse the upper immediate bits as a func7-like selector.
        if (func3 == INST_SLLI) begin
          legal = (func7[6:1] == SHIFT_HI_LOGIC);
          op2   = shamt;
        end else if (func3 == INST_SRI) begin
          legal = (func7[6:1] == SHIFT_HI_LOGIC) || (func7[6:1] == SHIFT_HI_ARITH);
          op2   = shamt;
        end else begin
          legal = 1'b1;
          op2   = imm_i;
        end
      end
      INST_TYPE_R: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
        op1       = rs1_data;
        op2       = rs2_data;
        legal     = (func7 == FUNC7_BASE) ||
                    ((func7 == FUNC7_ALT) && ((func3 == INST_ADD_SUB) || (func3 == INST_SRI)));
      end
      INST_TYPE_L: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        mem_ren   = 1'b1;
        op1       = rs1_data;
        op2       = imm_i;
        legal     = load_ok(func3, RV64);
      end
      INST_TYPE_S: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        mem_wen = 1'b1;
        op1     = rs1_data;
        op2     = imm_s;
        op3     = rs2_data;
        legal   = store_ok(func3, RV64);
      end
      INST_TYPE_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        op1     = rs1_data;
        op2     = rs2_data;
        op3     = imm_b;
        legal   = branch_ok(func3);
      end
      INST_JAL: begin
        writes_rd = 1'b1;
        op1       = pc;
        op2       = imm_j;
        legal     = 1'b1;
      end
      INST_JALR: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        op1       = rs1_data;
        op2       = imm_i;
        op3       = pc;
        legal     = (func3 == 3'd0);
      end
      INST_LUI: begin
        writes_rd = 1'b1;
        op1       = imm_u;
        legal     = 1'b1;
      end
      INST_AUIPC: begin
        writes_rd = 1'b1;
        op1       = pc;
        op2       = imm_u;
        legal     = 1'b1;
      end
      default: ;
    endcase
    // An illegal word travels down as a clean trap carrier with no side effects.
    if (!legal) begin
      op1       = '0;
      op2       = '0;
      op3       = '0;
      writes_rd = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
    end
  end

  assign illegal = ~legal;
  assign rd_addr = writes_rd ? inst[11:7] : 5'd0;
  assign reg_wen = writes_rd & (inst[11:7] != 5'd0);

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: load-use hazard detection plus the valid/ready output register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          SHAMT_W  = (XLEN == 64) ? 6 : 5,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  input  logic            ex_load_i,
  input  logic [4:0]      ex_rd_addr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] op3_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] dec_op1, dec_op2, dec_op3;
  logic [4:0]      dec_rd_addr;
  logic            dec_reg_wen, dec_mem_ren, dec_mem_wen, dec_illegal;
  logic            use_rs1, use_rs2;
  logic            hazard, load, clear;

  id_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_decode (
    .inst     (inst_i),
    .pc       (inst_addr_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .op1      (dec_op1),
    .op2      (dec_op2),
    .op3      (dec_op3),
    .rd_addr  (dec_rd_addr),
    .reg_wen  (dec_reg_wen),
    .mem_ren  (dec_mem_ren),
    .mem_wen  (dec_mem_wen),
    .illegal  (dec_illegal),
    .use_rs1  (use_rs1),
    .use_rs2  (use_rs2)
  );

  assign rs1_addr_o = use_rs1 ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = use_rs2 ? inst_i[24:20] : 5'd0;

  // Unused source fields are already forced to x0, which can never match a nonzero load rd.
  assign hazard  = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                   ((ex_rd_addr_i == rs1_addr_o) || (ex_rd_addr_i == rs2_addr_o));
  assign ready_o = (~valid_o | ready_i) & ~hazard & ~rst;

  assign load  = ~flush_i & valid_i & ready_o;
  assign clear = flush_i | (~load & ready_i);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_o     <= 1'b0;
      inst_o      <= NOP_INST;
      inst_addr_o <= '0;
      op1_o       <= '0;
      op2_o       <= '0;
      op3_o       <= '0;
      rd_addr_o   <= 5'd0;
      reg_wen_o   <= 1'b0;
      mem_ren_o   <= 1'b0;
      mem_wen_o   <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (load) begin
      valid_o     <= 1'b1;
      inst_o      <= inst_i;
      inst_addr_o <= inst_addr_i;
      op1_o       <= dec_op1;
      op2_o       <= dec_op2;
      op3_o       <= dec_op3;
      rd_addr_o   <= dec_rd_addr;
      reg_wen_o   <= dec_reg_wen;
      mem_ren_o   <= dec_mem_ren;
      mem_wen_o   <= dec_mem_wen;
      illegal_o   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table on an RV32 instance, handshake sequences, RV64 store/reset.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RV32 instance signals
  logic        rst, valid_i, ready_o, flush_i, ex_load_i, valid_o, ready_i;
  logic        reg_wen_o, mem_ren_o, mem_wen_o, illegal_o;
  logic [31:0] inst_i, inst_addr_i, rs1_data_i, rs2_data_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, op3_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_addr_i, rd_addr_o;

  // RV64 instance signals
  logic        w_rst, w_valid_i, w_ready_o, w_flush_i, w_ex_load_i, w_valid_o, w_ready_i;
  logic        w_reg_wen_o, w_mem_ren_o, w_mem_wen_o, w_illegal_o;
  logic [31:0] w_inst_i, w_inst_o;
  logic [63:0] w_inst_addr_i, w_rs1_data_i, w_rs2_data_i;
  logic [63:0] w_inst_addr_o, w_op1_o, w_op2_o, w_op3_o;
  logic [4:0]  w_rs1_addr_o, w_rs2_addr_o, w_ex_rd_addr_i, w_rd_addr_o;

  id_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i), .valid_i(valid_i),
    .ready_o(ready_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i), .valid_o(valid_o), .ready_i(ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o), .op3_o(op3_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .mem_ren_o(mem_ren_o),
    .mem_wen_o(mem_wen_o), .illegal_o(illegal_o)
  );

  id_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(w_rst), .inst_i(w_inst_i), .inst_addr_i(w_inst_addr_i), .valid_i(w_valid_i),
    .ready_o(w_ready_o), .rs1_addr_o(w_rs1_addr_o), .rs2_addr_o(w_rs2_addr_o),
    .rs1_data_i(w_rs1_data_i), .rs2_data_i(w_rs2_data_i), .flush_i(w_flush_i),
    .ex_load_i(w_ex_load_i), .ex_rd_addr_i(w_ex_rd_addr_i), .valid_o(w_valid_o),
    .ready_i(w_ready_i), .inst_o(w_inst_o), .inst_addr_o(w_inst_addr_o), .op1_o(w_op1_o),
    .op2_o(w_op2_o), .op3_o(w_op3_o), .rd_addr_o(w_rd_addr_o), .reg_wen_o(w_reg_wen_o),
    .mem_ren_o(w_mem_ren_o), .mem_wen_o(w_mem_wen_o), .illegal_o(w_illegal_o)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst, pc, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] op1, op2, op3;
    logic [4:0]  rd;
    logic        wen, ren, mwen, ill;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'hFFF08293, 32'h100,  32'd7,        32'd99,     5'd1,  5'd0,  32'd7,        32'hFFFFFFFF, 32'h0,    5'd5, 1'b1, 1'b0, 1'b0, 1'b0}; // addi x5,x1,-1
    vecs[1]  = '{32'h00218233, 32'h104,  32'h10,       32'h20,     5'd3,  5'd2,  32'h10,       32'h20,       32'h0,    5'd4, 1'b1, 1'b0, 1'b0, 1'b0}; // add
    vecs[2]  = '{32'h40838333, 32'h108,  32'h50,       32'h30,     5'd7,  5'd8,  32'h50,       32'h30,       32'h0,    5'd6, 1'b1, 1'b0, 1'b0, 1'b0}; // sub
    vecs[3]  = '{32'h00852483, 32'h10C,  32'h2000,     32'h55,     5'd10, 5'd0,  32'h2000,     32'h8,        32'h0,    5'd9, 1'b1, 1'b1, 1'b0, 1'b0}; // lw
    vecs[4]  = '{32'hFEB62E23, 32'h110,  32'h3000,     32'hCAFE,   5'd12, 5'd11, 32'h3000,     32'hFFFFFFFC, 32'hCAFE, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}; // sw x11,-4(x12)
    vecs[5]  = '{32'hFE2088E3, 32'h114,  32'h11,       32'h22,     5'd1,  5'd2,  32'h11,       32'h22,       32'hFFFFFFF0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // beq -16
    vecs[6]  = '{32'h001000EF, 32'h1000, 32'h1,        32'h2,      5'd0,  5'd0,  32'h1000,     32'h800,      32'h0,    5'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,+2048
    vecs[7]  = '{32'h00008067, 32'h2000, 32'h4444,     32'h5,      5'd1,  5'd0,  32'h4444,     32'h0,        32'h2000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // jalr x0 (wen forced 0)
    vecs[8]  = '{32'h12345137, 32'h2004, 32'h9,        32'h9,      5'd0,  5'd0,  32'h12345000, 32'h0,        32'h0,    5'd2, 1'b1, 1'b0, 1'b0, 1'b0}; // lui
    vecs[9]  = '{32'hFFFFF197, 32'h3000, 32'h9,        32'h9,      5'd0,  5'd0,  32'h3000,     32'hFFFFF000, 32'h0,    5'd3, 1'b1, 1'b0, 1'b0, 1'b0}; // auipc
    vecs[10] = '{32'h40335293, 32'h3004, 32'h80000000, 32'h9,      5'd6,  5'd0,  32'h80000000, 32'h3,        32'h0,    5'd5, 1'b1, 1'b0, 1'b0, 1'b0}; // srai
    vecs[11] = '{32'hFFFFFFFF, 32'h3008, 32'h1,        32'h2,      5'd0,  5'd0,  32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // bad opcode
    vecs[12] = '{32'h02838333, 32'h300C, 32'h1,        32'h2,      5'd7,  5'd8,  32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // sub func7=0x01
    vecs[13] = '{32'h40111093, 32'h3010, 32'h1,        32'h2,      5'd2,  5'd0,  32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // slli upper bits set
    vecs[14] = '{32'h00013083, 32'h3014, 32'h1,        32'h2,      5'd2,  5'd0,  32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // ld on RV32

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0; ex_load_i = 1'b0;
    ex_rd_addr_i = 5'd0; inst_i = NOP; inst_addr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    w_rst = 1'b1; w_valid_i = 1'b0; w_ready_i = 1'b1; w_flush_i = 1'b0; w_ex_load_i = 1'b0;
    w_ex_rd_addr_i = 5'd0; w_inst_i = NOP; w_inst_addr_i = '0; w_rs1_data_i = '0; w_rs2_data_i = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst_ready", ready_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_inst", inst_o, NOP);
    check("rst_op1", op1_o, 32'h0);
    check("rst_reg_wen", reg_wen_o, 1'b0);
    check("rst64_valid", w_valid_o, 1'b0);
    check("rst64_inst", w_inst_o, NOP);
    @(negedge clk);
    rst = 1'b0; w_rst = 1'b0;

    // Decode table, one instruction per cycle with ex always ready
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      inst_i = vecs[i].inst; inst_addr_i = vecs[i].pc;
      rs1_data_i = vecs[i].rs1d; rs2_data_i = vecs[i].rs2d;
      valid_i = 1'b1; ready_i = 1'b1;
      #1;
      check($sformatf("v%0d_rs1_addr", i), rs1_addr_o, vecs[i].rs1a);
      check($sformatf("v%0d_rs2_addr", i), rs2_addr_o, vecs[i].rs2a);
      check($sformatf("v%0d_ready", i), ready_o, 1'b1);
      @(posedge clk); #1;
      $display("vec %0d inst=%h pc=%h op1=%h op2=%h op3=%h rd=%0d ill=%b",
               i, vecs[i].inst, vecs[i].pc, op1_o, op2_o, op3_o, rd_addr_o, illegal_o);
      check($sformatf("v%0d_valid", i), valid_o, 1'b1);
      check($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
      check($sformatf("v%0d_pc", i), inst_addr_o, vecs[i].pc);
      check($sformatf("v%0d_op1", i), op1_o, vecs[i].op1);
      check($sformatf("v%0d_op2", i), op2_o, vecs[i].op2);
      check($sformatf("v%0d_op3", i), op3_o, vecs[i].op3);
      check($sformatf("v%0d_rd", i), rd_addr_o, vecs[i].rd);
      check($sformatf("v%0d_reg_wen", i), reg_wen_o, vecs[i].wen);
      check($sformatf("v%0d_mem_ren", i), mem_ren_o, vecs[i].ren);
      check($sformatf("v%0d_mem_wen", i), mem_wen_o, vecs[i].mwen);
      check($sformatf("v%0d_illegal", i), illegal_o, vecs[i].ill);
    end

    // Load-use hazard on add x4,x3,x2
    @(negedge clk);
    inst_i = 32'h00218233; inst_addr_i = 32'h400; rs1_data_i = 32'h10; rs2_data_i = 32'h20;
    valid_i = 1'b1; ready_i = 1'b1; ex_load_i = 1'b1; ex_rd_addr_i = 5'd3;
    #1 check("haz_rs1_ready", ready_o, 1'b0);
    @(posedge clk); #1;
    $display("hazard stall: valid_o=%b inst_o=%h", valid_o, inst_o);
    check("haz_bubble_valid", valid_o, 1'b0);
    check("haz_bubble_inst", inst_o, NOP);
    @(negedge clk);
    ex_rd_addr_i = 5'd2;
    #1 check("haz_rs2_ready", ready_o, 1'b0);
    ex_rd_addr_i = 5'd0;
    #1 check("haz_x0_ready", ready_o, 1'b1);
    ex_load_i = 1'b0; ex_rd_addr_i = 5'd3;
    #1 check("haz_drop_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    $display("hazard release: valid_o=%b rd=%0d", valid_o, rd_addr_o);
    check("haz_accept_valid", valid_o, 1'b1);
    check("haz_accept_rd", rd_addr_o, 5'd4);
    check("haz_accept_op1", op1_o, 32'h10);

    // Backpressure: held add must not be lost or overwritten by the waiting lui
    @(negedge clk);
    ready_i = 1'b0; valid_i = 1'b1; inst_i = 32'h12345137; inst_addr_i = 32'h404;
    #1 check("bp_ready", ready_o, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      $display("backpressure cycle %0d: inst_o=%h valid_o=%b", c, inst_o, valid_o);
      check($sformatf("bp%0d_valid", c), valid_o, 1'b1);
      check($sformatf("bp%0d_inst", c), inst_o, 32'h00218233);
      check($sformatf("bp%0d_op1", c), op1_o, 32'h10);
      check($sformatf("bp%0d_ready", c), ready_o, 1'b0);
    end
    @(negedge clk);
    ready_i = 1'b1;
    #1 check("bp_release_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    $display("backpressure release: inst_o=%h", inst_o);
    check("bp_next_inst", inst_o, 32'h12345137);
    check("bp_next_op1", op1_o, 32'h12345000);
    check("bp_next_pc", inst_addr_o, 32'h404);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("bp_drain_valid", valid_o, 1'b0);
    check("bp_drain_inst", inst_o, NOP);

    // Flush beats an acceptable incoming instruction
    @(negedge clk);
    inst_i = 32'hFFF08293; inst_addr_i = 32'h500; rs1_data_i = 32'd7;
    valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b1;
    #1 check("flush_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    $display("flush incoming: valid_o=%b inst_o=%h", valid_o, inst_o);
    check("flush_valid", valid_o, 1'b0);
    check("flush_inst", inst_o, NOP);
    @(negedge clk);
    flush_i = 1'b0;
    @(posedge clk); #1;
    check("flush_reload_valid", valid_o, 1'b1);
    // Flush also discards a held entry under backpressure
    @(negedge clk);
    ready_i = 1'b0; flush_i = 1'b1; inst_i = 32'h12345137;
    @(posedge clk); #1;
    $display("flush held: valid_o=%b op1=%h", valid_o, op1_o);
    check("flush_held_valid", valid_o, 1'b0);
    check("flush_held_op1", op1_o, 32'h0);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;

    // RV64: sd x2,-8(x1)
    @(negedge clk);
    w_inst_i = 32'hFE20BC23; w_inst_addr_i = 64'h8000_0000_0000_0010;
    w_rs1_data_i = 64'h1122_3344_5566_7788; w_rs2_data_i = 64'hDEAD_BEEF_00C0_FFEE;
    w_valid_i = 1'b1; w_ready_i = 1'b1;
    #1;
    check("sd_rs1_addr", w_rs1_addr_o, 5'd1);
    check("sd_rs2_addr", w_rs2_addr_o, 5'd2);
    @(posedge clk); #1;
    $display("rv64 sd: op1=%h op2=%h op3=%h", w_op1_o, w_op2_o, w_op3_o);
    check("sd_valid", w_valid_o, 1'b1);
    check("sd_op1", w_op1_o, 64'h1122_3344_5566_7788);
    check("sd_op2", w_op2_o, 64'hFFFF_FFFF_FFFF_FFF8);
    check("sd_op3", w_op3_o, 64'hDEAD_BEEF_00C0_FFEE);
    check("sd_mem_wen", w_mem_wen_o, 1'b1);
    check("sd_reg_wen", w_reg_wen_o, 1'b0);
    check("sd_illegal", w_illegal_o, 1'b0);
    check("sd_pc", w_inst_addr_o, 64'h8000_0000_0000_0010);
    // Stall with ld x1,0(x2) waiting, then reset mid-stall
    @(negedge clk);
    w_ready_i = 1'b0; w_inst_i = 32'h00013083;
    @(posedge clk); #1;
    check("sd_stall_mem_wen", w_mem_wen_o, 1'b1);
    @(negedge clk);
    w_rst = 1'b1;
    #1 check("rst64_mid_ready", w_ready_o, 1'b0);
    @(posedge clk); #1;
    $display("rv64 reset mid-stall: valid_o=%b inst_o=%h", w_valid_o, w_inst_o);
    check("rst64_mid_valid", w_valid_o, 1'b0);
    check("rst64_mid_inst", w_inst_o, NOP);
    check("rst64_mid_op2", w_op2_o, 64'h0);
    check("rst64_mid_op3", w_op3_o, 64'h0);
    check("rst64_mid_mem_wen", w_mem_wen_o, 1'b0);
    check("rst64_mid_pc", w_inst_addr_o, 64'h0);
    @(negedge clk);
    w_rst = 1'b0; w_ready_i = 1'b1;
    @(posedge clk); #1;
    $display("rv64 ld: op1=%h rd=%0d ill=%b", w_op1_o, w_rd_addr_o, w_illegal_o);
    check("ld64_illegal", w_illegal_o, 1'b0);
    check("ld64_mem_ren", w_mem_ren_o, 1'b1);
    check("ld64_rd", w_rd_addr_o, 5'd1);
    check("ld64_op1", w_op1_o, 64'h1122_3344_5566_7788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
